// File: rtl/kernel_stream_tx.sv
// kernel_stream_tx: holds one 3x3 kernel set in RAM and replays it as an AXI4-stream on start.
module kernel_stream_tx #(
  parameter int IN_CHANNEL = 2,
  parameter int WORD_WIDTH = 8,
  parameter int FILTERS = 8,
  parameter int KERNEL_BUF_WIDTH = 64,
  localparam int BEATS_PER_TAP = FILTERS * IN_CHANNEL * WORD_WIDTH / KERNEL_BUF_WIDTH,
  localparam int TOTAL_BEATS = 9 * BEATS_PER_TAP,
  localparam int AW = $clog2(TOTAL_BEATS)
) (
  input  logic                        i_aclk,
  input  logic                        i_areset,
  input  logic                        i_wr_en,
  input  logic [AW-1:0]               i_wr_addr,
  input  logic [KERNEL_BUF_WIDTH-1:0] i_wr_data,
  input  logic                        i_start,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_tvalid,
  input  logic                        i_tready,
  output logic [KERNEL_BUF_WIDTH-1:0] o_tdata,
  output logic                        o_tlast
);
  localparam logic [AW-1:0] LAST = AW'(TOTAL_BEATS - 1);
  typedef enum logic [1:0] {IDLE, PRIME, SEND} state_t;
  state_t state, state_n;
  logic [KERNEL_BUF_WIDTH-1:0] mem [TOTAL_BEATS];
  logic [KERNEL_BUF_WIDTH-1:0] ram_q, skid_data;
  logic [AW-1:0] ptr;
  logic [1:0] cnt, cnt_after;
  logic all_issued, rd_v, rd_last, skid_last, issue, pop, fin, space;
  assign o_busy = state != IDLE;
  assign o_tvalid = cnt != 2'd0;
  assign pop = o_tvalid && i_tready;
  assign fin = state == SEND && pop && o_tlast;
  assign cnt_after = cnt - {1'b0, pop};
  // count the in-flight RAM read so the two-entry buffer can never overflow
  assign space = cnt_after + {1'b0, rd_v} < 2'd2;
  always_comb begin
    state_n = state;
    issue = 1'b0;
    case (state)
      IDLE: state_n = i_start ? PRIME : IDLE;
      PRIME: begin
        issue = 1'b1;
        state_n = SEND;
      end
      SEND: begin
        issue = !all_issued && space;
        state_n = fin ? IDLE : SEND;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge i_aclk) begin
    if (i_wr_en && !o_busy && 32'(i_wr_addr) < TOTAL_BEATS) mem[i_wr_addr] <= i_wr_data;
    if (issue) ram_q <= mem[ptr];
  end
  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      state <= IDLE;
      ptr <= '0;
      all_issued <= 1'b0;
      rd_v <= 1'b0;
      rd_last <= 1'b0;
      cnt <= 2'd0;
      o_tdata <= '0;
      o_tlast <= 1'b0;
      skid_data <= '0;
      skid_last <= 1'b0;
      o_done <= 1'b0;
    end else begin
      state <= state_n;
      o_done <= fin;
      rd_v <= issue;
      if (issue) rd_last <= ptr == LAST;
      if (fin) begin
        ptr <= '0;
        all_issued <= 1'b0;
      end else if (issue) begin
        if (ptr == LAST) all_issued <= 1'b1;
        else ptr <= ptr + 1'b1;
      end
      if (pop) begin
        o_tdata <= skid_data;
        o_tlast <= skid_last;
      end
      // arriving beat lands in the first free slot after this cycle's pop
      if (rd_v && cnt_after == 2'd0) begin
        o_tdata <= ram_q;
        o_tlast <= rd_last;
      end else if (rd_v) begin
        skid_data <= ram_q;
        skid_last <= rd_last;
      end
      cnt <= cnt_after + {1'b0, rd_v};
    end
  end
endmodule

// File: tb/tb_kernel_stream_tx.sv
// tb_kernel_stream_tx: directed checks of kernel_stream_tx latency, ordering, backpressure and reset.
module tb_kernel_stream_tx;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic i_areset = 1'b1, i_wr_en = 1'b0, i_start = 1'b0, i_tready = 1'b0;
  logic [4:0] i_wr_addr = '0;
  logic [63:0] i_wr_data = '0;
  logic o_busy, o_done, o_tvalid, o_tlast;
  logic [63:0] o_tdata;
  logic [63:0] exp_d [18];
  int errors = 0, checks = 0;
  kernel_stream_tx dut (
    .i_aclk(clk), .i_areset(i_areset), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
    .i_wr_data(i_wr_data), .i_start(i_start), .o_busy(o_busy), .o_done(o_done),
    .o_tvalid(o_tvalid), .i_tready(i_tready), .o_tdata(o_tdata), .o_tlast(o_tlast)
  );
  task automatic step();
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic go(input bit pre, input bit wr0, input logic [63:0] d0);
    if (!pre) begin
      i_start = 1'b1;
      i_wr_en = wr0;
      i_wr_addr = 5'd0;
      i_wr_data = d0;
      step();
    end
    i_start = 1'b0;
    i_wr_en = 1'b0;
    chk("busy_after_start", o_busy, 1);
    chk("tvalid_lat1", o_tvalid, 0);
    step();
    chk("tvalid_lat2", o_tvalid, 0);
    step();
    chk("tvalid_lat3", o_tvalid, 1);
    chk("first_data", o_tdata, exp_d[0]);
  endtask
  task automatic recv(input int mode, input int nbeats, input bit inject, input bit chain);
    int idx = 0, cyc = 0, first_v = -1, hs = -1000, done_cnt = 0;
    bit hold = 0, injd = 0;
    logic [63:0] hd = '0;
    logic hl = 1'b0;
    while (!(idx == nbeats && (nbeats < 18 || cyc > hs + 1)) && cyc < 400) begin
      i_start = 1'b0;
      i_wr_en = 1'b0;
      if (first_v < 0 && o_tvalid) first_v = cyc;
      case (mode)
        0: i_tready = 1'b1;
        1: i_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: i_tready = first_v >= 0 && cyc - first_v >= 10;
      endcase
      if (hold) begin
        chk("hold_valid", o_tvalid, 1);
        chk("hold_data", o_tdata, hd);
        chk("hold_last", o_tlast, hl);
      end
      hold = o_tvalid && !i_tready;
      hd = o_tdata;
      hl = o_tlast;
      if (o_tvalid && i_tready) begin
        chk($sformatf("beat%0d_data", idx), o_tdata, exp_d[idx]);
        chk($sformatf("beat%0d_last", idx), o_tlast, idx == 17);
        idx++;
        if (idx == 18) hs = cyc;
      end
      if (o_done) begin
        done_cnt++;
        chk("done_timing", cyc, hs + 1);
        chk("busy_at_done", o_busy, 0);
        if (chain) i_start = 1'b1;
      end
      if (inject && idx == 5 && !injd) begin
        injd = 1;
        i_start = 1'b1;
        i_wr_en = 1'b1;
        i_wr_addr = 5'd3;
        i_wr_data = 64'hDEAD_BEEF;
      end
      step();
      cyc++;
    end
    chk("beats", idx, nbeats);
    if (nbeats == 18) begin
      chk("done_count", done_cnt, 1);
      chk("stream_len", hs - first_v, mode == 0 ? 17 : mode == 1 ? 35 : 27);
    end
  endtask
  initial begin
    step();
    step();
    i_areset = 1'b0;
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_tvalid", o_tvalid, 0);
    chk("rst_tlast", o_tlast, 0);
    chk("rst_tdata", o_tdata, 0);
    for (int k = 0; k < 18; k++) begin
      exp_d[k] = 64'h0101_0101_0101_0101 * k;
      i_wr_en = 1'b1;
      i_wr_addr = 5'(k);
      i_wr_data = exp_d[k];
      step();
    end
    i_wr_en = 1'b0;
    i_tready = 1'b1;
    go(0, 0, 0);
    recv(0, 18, 0, 1);
    go(1, 0, 0);
    recv(1, 18, 0, 0);
    step();
    chk("idle_busy", o_busy, 0);
    chk("idle_tvalid", o_tvalid, 0);
    go(0, 0, 0);
    recv(0, 18, 1, 0);
    step();
    step();
    chk("no_requeue_busy", o_busy, 0);
    chk("no_requeue_tvalid", o_tvalid, 0);
    go(0, 0, 0);
    recv(0, 18, 0, 0);
    go(0, 0, 0);
    recv(0, 9, 0, 0);
    chk("pre_reset_beat9", o_tdata, exp_d[9]);
    i_areset = 1'b1;
    step();
    i_areset = 1'b0;
    chk("abort_tvalid", o_tvalid, 0);
    chk("abort_busy", o_busy, 0);
    chk("abort_done", o_done, 0);
    chk("abort_tlast", o_tlast, 0);
    chk("abort_tdata", o_tdata, 0);
    step();
    chk("abort_done_after", o_done, 0);
    go(0, 0, 0);
    recv(0, 18, 0, 0);
    i_wr_en = 1'b1;
    i_wr_addr = 5'd20;
    i_wr_data = 64'hBAD0_BAD0_BAD0_BAD0;
    step();
    i_wr_en = 1'b0;
    exp_d[0] = 64'h0123_4567_89AB_CDEF;
    go(0, 1, exp_d[0]);
    recv(0, 18, 0, 0);
    go(0, 0, 0);
    recv(2, 18, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
